// File: rtl/debug_trace_hub.sv
// Debug bus hub: probe window, circular retire-trace buffer, PC breakpoints
// with halt/single-step control for the pipeline stall logic.
module debug_trace_hub #(
  parameter int NCH   = 96,
  parameter int DEPTH = 16,
  parameter int NBP   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        chk_addr,
  output logic [31:0]        chk_data,
  output logic [31:0]        chk_pc,
  input  logic               cfg_we,
  input  logic [31:0]        cfg_wdata,
  input  logic [NCH*32-1:0]  probe_bus,
  input  logic               retire_valid,
  input  logic [31:0]        retire_pc,
  input  logic [31:0]        retire_is,
  output logic               halt_req,
  output logic [4:0]         rf_debug_addr,
  input  logic [31:0]        rf_debug_data,
  output logic [15:0]        imu_debug_addr,
  input  logic [31:0]        imu_debug_data,
  output logic [15:0]        dmu_debug_addr,
  input  logic [31:0]        dmu_debug_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [31:0]   chk_data_q, chk_data_d;
  logic [31:0]   chk_pc_q, chk_pc_d;
  logic          halt_q, halt_d;
  logic          step_q, step_d;
  logic          trace_en_q, trace_en_d;
  logic          bp_en_q, bp_en_d;
  logic [31:0]   bp_q [NBP];
  logic [31:0]   bp_d [NBP];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [31:0]   rcnt_q, rcnt_d;
  logic [31:0]   pc_mem_q [DEPTH];
  logic [31:0]   is_mem_q [DEPTH];

  logic [31:0]   probe_ch [NCH];
  logic [3:0]    region;
  logic [11:0]   off;
  logic [10:0]   age;
  logic          age_ok;
  logic [AW-1:0] rd_idx;
  logic          ctl_wr, ctrl_wr, trace_clr, trace_wr, bp_hit;
  logic          unused_addr;

  for (genvar i = 0; i < NCH; i++) begin : g_probe
    assign probe_ch[i] = probe_bus[32*i +: 32];
  end

  assign region         = chk_addr[19:16];
  assign off            = chk_addr[11:0];
  assign age            = off[11:1];
  assign age_ok         = 32'(age) < 32'(count_q);
  assign rd_idx         = wr_ptr_q - AW'(1) - age[AW-1:0];
  assign rf_debug_addr  = chk_addr[4:0];
  assign imu_debug_addr = chk_addr[15:0];
  assign dmu_debug_addr = chk_addr[15:0];
  assign unused_addr    = ^chk_addr[31:20];

  assign ctl_wr    = cfg_we && (region == 4'h5);
  assign ctrl_wr   = ctl_wr && (off == 12'h000);
  assign trace_clr = ctrl_wr && cfg_wdata[4];
  // A clear in the same cycle as a retire drops that retire's entry.
  assign trace_wr  = retire_valid && trace_en_q && !trace_clr;

  always_comb begin
    bp_hit = 1'b0;
    for (int k = 0; k < NBP; k++) begin
      if (retire_pc == bp_q[k]) bp_hit = 1'b1;
    end
    bp_hit = bp_hit && bp_en_q;
  end

  always_comb begin
    chk_data_d = 32'h0;
    case (region)
      4'h0: if (32'(off) < NCH) chk_data_d = probe_ch[off[PW-1:0]];
      4'h1: chk_data_d = rf_debug_data;
      4'h2: chk_data_d = imu_debug_data;
      4'h3: chk_data_d = dmu_debug_data;
      4'h4: if (age_ok) chk_data_d = off[0] ? is_mem_q[rd_idx] : pc_mem_q[rd_idx];
      4'h5: begin
        if (off == 12'h000) chk_data_d = {30'h0, bp_en_q, trace_en_q};
        if (off == 12'h001) chk_data_d = {ovf_q, halt_q, step_q, 13'h0, 16'(count_q)};
        if (off == 12'h010) chk_data_d = rcnt_q;
        for (int k = 0; k < NBP; k++) begin
          if (off == 12'(k + 2)) chk_data_d = bp_q[k];
        end
      end
      default: chk_data_d = 32'h0;
    endcase
  end

  always_comb begin
    chk_pc_d   = chk_pc_q;
    halt_d     = halt_q;
    step_d     = step_q;
    trace_en_d = trace_en_q;
    bp_en_d    = bp_en_q;
    bp_d       = bp_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    rcnt_d     = rcnt_q;
    if (ctrl_wr) begin
      trace_en_d = cfg_wdata[0];
      bp_en_d    = cfg_wdata[1];
      if (cfg_wdata[2] || cfg_wdata[3]) halt_d = 1'b0;
      if (cfg_wdata[3]) step_d = 1'b1;
    end
    for (int k = 0; k < NBP; k++) begin
      if (ctl_wr && off == 12'(k + 2)) bp_d[k] = cfg_wdata;
    end
    // Retire effects are applied after commands so a hit or step completion wins.
    if (retire_valid) begin
      rcnt_d   = rcnt_q + 32'd1;
      chk_pc_d = retire_pc;
      if (bp_hit) halt_d = 1'b1;
      if (step_d) begin
        halt_d = 1'b1;
        step_d = 1'b0;
      end
    end
    if (trace_clr) begin
      wr_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else if (trace_wr) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      if (count_q == (AW+1)'(DEPTH)) ovf_d = 1'b1;
      else count_d = count_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      chk_data_q <= '0;
      chk_pc_q   <= '0;
      halt_q     <= 1'b0;
      step_q     <= 1'b0;
      trace_en_q <= 1'b0;
      bp_en_q    <= 1'b0;
      for (int k = 0; k < NBP; k++) bp_q[k] <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      rcnt_q     <= '0;
    end else begin
      chk_data_q <= chk_data_d;
      chk_pc_q   <= chk_pc_d;
      halt_q     <= halt_d;
      step_q     <= step_d;
      trace_en_q <= trace_en_d;
      bp_en_q    <= bp_en_d;
      bp_q       <= bp_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      rcnt_q     <= rcnt_d;
    end
  end

  // Trace storage is qualified by count, so it needs no reset.
  always_ff @(posedge clk) begin
    if (trace_wr && !rst) begin
      pc_mem_q[wr_ptr_q] <= retire_pc;
      is_mem_q[wr_ptr_q] <= retire_is;
    end
  end

  assign chk_data = chk_data_q;
  assign chk_pc   = chk_pc_q;
  assign halt_req = halt_q;

endmodule
